// File: rtl/control_sequencer.sv
// Microcoded control sequencer for the shared 16-bit datapath bus.
// Optional HALT opcode support is enabled by defining CU_HALT_EN.
module control_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instrValid,
    output logic        instrReady,
    output logic        done,
    output logic        halted,
    output logic [2:0]  opControl,
    output logic        ALUin0,
    output logic        ALUin1,
    output logic        ALUOutLatch,
    output logic        ALUOutEn,
    output logic        PCOutEn,
    output logic [3:0]  regLatch,
    output logic [3:0]  regOut,
    output logic [3:0]  dbg_state
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ALU_A = 4'd1;
    localparam logic [3:0] S_ALU_B = 4'd2;
    localparam logic [3:0] S_ALU_X = 4'd3;
    localparam logic [3:0] S_ALU_W = 4'd4;
    localparam logic [3:0] S_MOV   = 4'd5;
    localparam logic [3:0] S_PCRD  = 4'd6;
    localparam logic [3:0] S_NOP   = 4'd7;
`ifdef CU_HALT_EN
    localparam logic [3:0] S_HALT  = 4'd8;
`endif

    logic [3:0] state, state_nxt;
    logic [1:0] rd_q, rs1_q, rs2_q;
    logic [1:0] rd_nxt, rs1_nxt, rs2_nxt;
    logic [3:0] opcode;
    logic       accept;
    logic       instr_unused;

    assign opcode       = instr[15:12];
    assign accept       = instrValid && instrReady;
    assign instr_unused = ^instr[5:0];
    assign dbg_state    = state;

    always_comb begin
        state_nxt = state;
        rd_nxt    = rd_q;
        rs1_nxt   = rs1_q;
        rs2_nxt   = rs2_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    rd_nxt  = instr[11:10];
                    rs1_nxt = instr[9:8];
                    rs2_nxt = instr[7:6];
                    if (!opcode[3])          state_nxt = S_ALU_A;
                    else if (opcode == 4'h8) state_nxt = S_MOV;
                    else if (opcode == 4'h9) state_nxt = S_PCRD;
`ifdef CU_HALT_EN
                    else if (opcode == 4'hF) state_nxt = S_HALT;
`endif
                    else                     state_nxt = S_NOP;
                end
            end
            S_ALU_A: state_nxt = S_ALU_B;
            S_ALU_B: state_nxt = S_ALU_X;
            S_ALU_X: state_nxt = S_ALU_W;
            S_ALU_W: state_nxt = S_IDLE;
            S_MOV:   state_nxt = S_IDLE;
            S_PCRD:  state_nxt = S_IDLE;
            S_NOP:   state_nxt = S_IDLE;
`ifdef CU_HALT_EN
            S_HALT:  state_nxt = S_HALT;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes are decoded from the upcoming state so every output is a flop.
    logic       done_nxt, a0_nxt, a1_nxt, xl_nxt, ae_nxt, pe_nxt;
    logic [3:0] rl_nxt, ro_nxt;

    always_comb begin
        done_nxt = 1'b0;
        a0_nxt   = 1'b0;
        a1_nxt   = 1'b0;
        xl_nxt   = 1'b0;
        ae_nxt   = 1'b0;
        pe_nxt   = 1'b0;
        rl_nxt   = 4'b0000;
        ro_nxt   = 4'b0000;
        case (state_nxt)
            S_ALU_A: begin
                ro_nxt = 4'b0001 << rs1_nxt;
                a0_nxt = 1'b1;
            end
            S_ALU_B: begin
                ro_nxt = 4'b0001 << rs2_nxt;
                a1_nxt = 1'b1;
            end
            S_ALU_X: xl_nxt = 1'b1;
            S_ALU_W: begin
                ae_nxt   = 1'b1;
                rl_nxt   = 4'b0001 << rd_nxt;
                done_nxt = 1'b1;
            end
            S_MOV: begin
                ro_nxt   = 4'b0001 << rs1_nxt;
                rl_nxt   = 4'b0001 << rd_nxt;
                done_nxt = 1'b1;
            end
            S_PCRD: begin
                pe_nxt   = 1'b1;
                rl_nxt   = 4'b0001 << rd_nxt;
                done_nxt = 1'b1;
            end
            S_NOP:   done_nxt = 1'b1;
            default: done_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rd_q        <= 2'd0;
            rs1_q       <= 2'd0;
            rs2_q       <= 2'd0;
            instrReady  <= 1'b1;
            done        <= 1'b0;
            halted      <= 1'b0;
            opControl   <= 3'd0;
            ALUin0      <= 1'b0;
            ALUin1      <= 1'b0;
            ALUOutLatch <= 1'b0;
            ALUOutEn    <= 1'b0;
            PCOutEn     <= 1'b0;
            regLatch    <= 4'b0000;
            regOut      <= 4'b0000;
        end else begin
            state       <= state_nxt;
            rd_q        <= rd_nxt;
            rs1_q       <= rs1_nxt;
            rs2_q       <= rs2_nxt;
            instrReady  <= (state_nxt == S_IDLE);
            done        <= done_nxt;
`ifdef CU_HALT_EN
            halted      <= (state_nxt == S_HALT);
`else
            halted      <= 1'b0;
`endif
            if (accept && !opcode[3])
                opControl <= opcode[2:0];
            ALUin0      <= a0_nxt;
            ALUin1      <= a1_nxt;
            ALUOutLatch <= xl_nxt;
            ALUOutEn    <= ae_nxt;
            PCOutEn     <= pe_nxt;
            regLatch    <= rl_nxt;
            regOut      <= ro_nxt;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random
// instruction streams compared cycle by cycle against a per-instruction model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        instrValid = 1'b0;
    logic        instrReady, done, halted;
    logic [2:0]  opControl;
    logic        ALUin0, ALUin1, ALUOutLatch, ALUOutEn, PCOutEn;
    logic [3:0]  regLatch, regOut, dbg_state;

    control_sequencer dut (
        .clk(clk), .rst(rst), .instr(instr), .instrValid(instrValid),
        .instrReady(instrReady), .done(done), .halted(halted),
        .opControl(opControl), .ALUin0(ALUin0), .ALUin1(ALUin1),
        .ALUOutLatch(ALUOutLatch), .ALUOutEn(ALUOutEn), .PCOutEn(PCOutEn),
        .regLatch(regLatch), .regOut(regOut), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the instruction in flight and which of its cycles we are in.
    bit          m_busy = 0;
    bit          m_halt = 0;
    int          m_k = 0;
    int          m_len = 0;
    logic [15:0] m_instr = 16'h0;
    logic [2:0]  m_oc = 3'd0;
    int          m_accepts = 0;
    int          m_dones = 0;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001;
        return one << idx;
    endfunction

    function automatic int op_len(input logic [3:0] op);
        return (op < 4'h8) ? 4 : 1;
    endfunction

    function automatic logic [18:0] model_expect();
        logic       ready, dn, hl, a0, a1, xl, ae, pe;
        logic [3:0] rl, ro, op;
        ready = !m_busy && !m_halt;
        hl = m_halt;
        dn = 0; a0 = 0; a1 = 0; xl = 0; ae = 0; pe = 0;
        rl = 4'b0; ro = 4'b0;
        op = m_instr[15:12];
        if (m_busy) begin
            if (op < 4'h8) begin
                if (m_k == 1) begin ro = onehot(m_instr[9:8]); a0 = 1; end
                if (m_k == 2) begin ro = onehot(m_instr[7:6]); a1 = 1; end
                if (m_k == 3) xl = 1;
                if (m_k == 4) begin ae = 1; rl = onehot(m_instr[11:10]); dn = 1; end
            end else if (op == 4'h8) begin
                ro = onehot(m_instr[9:8]); rl = onehot(m_instr[11:10]); dn = 1;
            end else if (op == 4'h9) begin
                pe = 1; rl = onehot(m_instr[11:10]); dn = 1;
            end else begin
                dn = 1;
            end
        end
        return {ready, dn, hl, m_oc, a0, a1, xl, ae, pe, rl, ro};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {instrReady, done, halted, opControl, ALUin0, ALUin1, ALUOutLatch,
                ALUOutEn, PCOutEn, regLatch, regOut};
    endfunction

    task automatic model_step(input logic v, input logic [15:0] w);
        if (m_halt) begin
        end else if (m_busy) begin
            if (m_k == m_len) m_busy = 0;
            else m_k++;
        end else if (v) begin
            m_accepts++;
            m_instr = w;
            if (!w[15]) m_oc = w[14:12];
`ifdef CU_HALT_EN
            if (w[15:12] == 4'hF) m_halt = 1;
            else begin m_busy = 1; m_k = 1; m_len = op_len(w[15:12]); end
`else
            m_busy = 1; m_k = 1; m_len = op_len(w[15:12]);
`endif
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_halt = 0; m_k = 0; m_oc = 3'd0;
    endtask

    task automatic test_reset();
        logic [18:0] e;
        @(negedge clk);
        n_checks++;
        e = model_expect();
        if (obs_vec() !== e) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", obs_vec(), e);
        end
        rst = 1'b0;
        // Start an ALU op, then reset during its second cycle (ALU_B).
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_checks++;
                e = model_expect();
                if (obs_vec() !== e) begin
                    n_fail++; $display("FAIL reset_pre c%0d: got %h expected %h", c, obs_vec(), e);
                end
            end
            if (c == 2) break;
            instrValid = (c == 0); instr = 16'h3E40;
            @(posedge clk);
            model_step(instrValid, instr);
        end
        instrValid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        e = model_expect();
        if (obs_vec() !== e) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h", obs_vec(), e);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            e = model_expect();
            if (obs_vec() !== e) begin
                n_fail++; $display("FAIL reset_after c%0d: got %h expected %h", c, obs_vec(), e);
            end
            instrValid = (c == 3); instr = 16'h2E40;
            @(posedge clk);
            model_step(instrValid, instr);
        end
        instrValid = 1'b0;
    endtask

    task automatic test_alu_op();
        logic [18:0] e;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            n_checks++;
            e = model_expect();
            if (obs_vec() !== e) begin
                n_fail++; $display("FAIL alu c%0d: got %h expected %h", c, obs_vec(), e);
            end
            if (c == 1 && {regOut, ALUin0, opControl} !== {4'b0100, 1'b1, 3'd2}) begin
                n_fail++; $display("FAIL alu_c1: got %b%b expected 01001", regOut, ALUin0);
            end
            if (c == 2 && {regOut, ALUin1} !== 5'b0010_1) begin
                n_fail++; $display("FAIL alu_c2: got %b%b expected 00101", regOut, ALUin1);
            end
            if (c == 4 && {ALUOutEn, regLatch, done} !== 6'b1_1000_1) begin
                n_fail++; $display("FAIL alu_c4: got %b%b%b expected 110001", ALUOutEn, regLatch, done);
            end
            if (c == 5 && instrReady !== 1'b1) begin
                n_fail++; $display("FAIL alu_ready: got %b expected 1", instrReady);
            end
            if (c >= 1 && c <= 5) n_checks++;
            instrValid = (c == 0); instr = 16'h2E40;
            @(posedge clk);
            model_step(instrValid, instr);
        end
        instrValid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [18:0] e;
        int acc0;
        acc0 = m_accepts;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            e = model_expect();
            if (obs_vec() !== e) begin
                n_fail++; $display("FAIL b2b c%0d: got %h expected %h", c, obs_vec(), e);
            end
            if (c == 1) begin
                n_checks++;
                if ({regOut, regLatch, done} !== 9'b0010_0001_1) begin
                    n_fail++; $display("FAIL mov_c1: got %b %b %b expected 0010 0001 1", regOut, regLatch, done);
                end
            end
            if (c == 3) begin
                n_checks++;
                if ({PCOutEn, regLatch, done} !== 6'b1_1000_1) begin
                    n_fail++; $display("FAIL pcrd_c3: got %b %b %b expected 1 1000 1", PCOutEn, regLatch, done);
                end
            end
            instrValid = (c < 3); instr = (c == 0) ? 16'h8100 : 16'h9C00;
            @(posedge clk);
            model_step(instrValid, instr);
        end
        instrValid = 1'b0;
        n_checks++;
        if (m_accepts - acc0 != 2) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", m_accepts - acc0);
        end
    endtask

    task automatic test_holdoff();
        logic [18:0] e;
        int d0;
        d0 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            e = model_expect();
            if (obs_vec() !== e) begin
                n_fail++; $display("FAIL hold c%0d: got %h expected %h", c, obs_vec(), e);
            end
            if (done) d0++;
            if (c == 6) begin
                n_checks++;
                if ({ALUin0, regOut, opControl} !== {1'b1, 4'b0100, 3'd7}) begin
                    n_fail++; $display("FAIL hold_accept: got %b %b %0d expected 1 0100 7", ALUin0, regOut, opControl);
                end
            end
            instrValid = (c <= 5); instr = (c == 0) ? 16'h16C0 : 16'h7280;
            @(posedge clk);
            model_step(instrValid, instr);
        end
        instrValid = 1'b0;
        n_checks++;
        if (d0 != 2) begin
            n_fail++; $display("FAIL hold_dones: got %0d expected 2", d0);
        end
    endtask

    task automatic test_random();
        logic [18:0] e;
        logic [15:0] w;
        bit          pend;
        int          acc0, dn, acc_before, cyc;
        acc0 = m_accepts; dn = 0; pend = 0; cyc = 0; w = 16'h0;
        while ((m_accepts - acc0 < 200 || m_busy) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            n_checks += 2;
            e = model_expect();
            if (obs_vec() !== e) begin
                n_fail++; $display("FAIL rand cyc%0d: got %h expected %h", cyc, obs_vec(), e);
            end
            if ($countones({ALUOutEn, PCOutEn, regOut}) > 1) begin
                n_fail++; $display("FAIL bus_excl cyc%0d: got %b expected at most one driver", cyc, {ALUOutEn, PCOutEn, regOut});
            end
            if (done) dn++;
            if (!pend && (m_accepts - acc0 < 200) && $urandom_range(0, 2) != 0) begin
                w = 16'($urandom);
`ifdef CU_HALT_EN
                if (w[15:12] == 4'hF) w[15:12] = 4'hE;
`endif
                pend = 1;
            end
            instrValid = pend; instr = pend ? w : 16'($urandom);
            @(posedge clk);
            acc_before = m_accepts;
            model_step(instrValid, instr);
            if (m_accepts != acc_before) pend = 0;
        end
        instrValid = 1'b0;
        n_checks++;
        if (cyc >= 4000) begin
            n_fail++; $display("FAIL rand_timeout: got %0d accepts expected 200", m_accepts - acc0);
        end
        n_checks++;
        if (dn != m_accepts - acc0) begin
            n_fail++; $display("FAIL rand_dones: got %0d expected %0d", dn, m_accepts - acc0);
        end
    endtask

    task automatic test_halt();
        logic [18:0] e;
`ifdef CU_HALT_EN
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            n_checks++;
            e = model_expect();
            if (obs_vec() !== e) begin
                n_fail++; $display("FAIL halt c%0d: got %h expected %h", c, obs_vec(), e);
            end
            if (c >= 1) begin
                n_checks++;
                if ({halted, instrReady, done} !== 3'b100) begin
                    n_fail++; $display("FAIL halt_hold c%0d: got %b expected 100", c, {halted, instrReady, done});
                end
            end
            instrValid = 1'b1; instr = (c == 0) ? 16'hF000 : 16'h2E40;
            @(posedge clk);
            model_step(instrValid, instr);
        end
        instrValid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({halted, instrReady} !== 2'b01) begin
            n_fail++; $display("FAIL halt_clear: got %b expected 01", {halted, instrReady});
        end
        @(negedge clk);
        rst = 1'b0;
`else
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            e = model_expect();
            if (obs_vec() !== e) begin
                n_fail++; $display("FAIL halt_nop c%0d: got %h expected %h", c, obs_vec(), e);
            end
            if (c == 1) begin
                n_checks++;
                if ({done, halted, instrReady} !== 3'b100) begin
                    n_fail++; $display("FAIL halt_nop_done: got %b expected 100", {done, halted, instrReady});
                end
            end
            if (c == 2) begin
                n_checks++;
                if ({done, instrReady} !== 2'b01) begin
                    n_fail++; $display("FAIL halt_nop_ready: got %b expected 01", {done, instrReady});
                end
            end
            instrValid = (c == 0); instr = 16'hF000;
            @(posedge clk);
            model_step(instrValid, instr);
        end
        instrValid = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_alu_op();
        test_back_to_back();
        test_holdoff();
        test_random();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
